// File: rtl/pwm_timer_if.sv
// pwm_timer_if: bundles the timer's configuration inputs and its
// core-facing / pin-facing outputs into one port.
//
// Signals (direction as seen by the timer):
//   enable_i          in   run timer; 0 forces Idle
//   period_i          in   top count; period = period_i+1 ticks
//   prescale_i        in   tick every prescale_i+1 clocks
//   polarity_i        in   0: active-high output, 1: active-low output
//   pwm_value_i       in   duty value from the execution core
//   start_o           out  one-cycle pulse at period start
//   global_counter_o  out  {period_cnt, cnt}
//   pwm_o             out  PWM pin
//   duty_o            out  current shadow duty value
//
// Modports: master drives the configuration (core / bench side),
// slave is the timer itself.
interface pwm_timer_if #(
  parameter int COUNTER_WIDTH        = 10,
  parameter int GLOBAL_COUNTER_WIDTH = 20,
  parameter int PRESCALE_WIDTH       = 8
);

  logic                            enable_i;
  logic [COUNTER_WIDTH-1:0]        period_i;
  logic [PRESCALE_WIDTH-1:0]       prescale_i;
  logic                            polarity_i;
  logic [COUNTER_WIDTH-1:0]        pwm_value_i;
  logic                            start_o;
  logic [GLOBAL_COUNTER_WIDTH-1:0] global_counter_o;
  logic                            pwm_o;
  logic [COUNTER_WIDTH-1:0]        duty_o;

  modport master (
    output enable_i, period_i, prescale_i, polarity_i, pwm_value_i,
    input  start_o, global_counter_o, pwm_o, duty_o
  );

  modport slave (
    input  enable_i, period_i, prescale_i, polarity_i, pwm_value_i,
    output start_o, global_counter_o, pwm_o, duty_o
  );

endinterface

// File: rtl/pwm_timer.sv
// pwm_timer: timing and output stage around the PPWM execution core.
// Produces the period start pulse and global counter for the core,
// latches the core's duty value into a shadow register at each period
// start, and drives the PWM pin from a compare of the in-period counter
// against the shadow value. Every output is registered.
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    pwm_timer_if.slave (configuration in, start/counter/pwm/duty out)
module pwm_timer #(
  parameter int COUNTER_WIDTH        = 10,
  parameter int GLOBAL_COUNTER_WIDTH = 20,
  parameter int PRESCALE_WIDTH       = 8
) (
  input logic        clk,
  input logic        rst_n,
  pwm_timer_if.slave bus
);

  localparam int PERIOD_WIDTH = GLOBAL_COUNTER_WIDTH - COUNTER_WIDTH;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [COUNTER_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic [PERIOD_WIDTH-1:0]   period_cnt_q, period_cnt_d;
  logic [COUNTER_WIDTH-1:0]  shadow_q, shadow_d;
  logic                      start_q, start_d;
  logic                      pwm_q, pwm_d;
  logic                      tick;
  logic                      wrap;

  // Next-state logic. Entry from Idle behaves like a period start
  // (shadow load + start pulse) but leaves the period count at zero.
  // Dropping enable wins over a wrap on the same edge. The >= compares
  // let a shrinking prescale or period take effect at once instead of
  // waiting for the counter to roll over.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pre_d        = pre_q;
    period_cnt_d = period_cnt_q;
    shadow_d     = shadow_q;
    start_d      = 1'b0;
    tick         = 1'b0;
    wrap         = 1'b0;

    if (state_q == ST_IDLE) begin
      cnt_d        = '0;
      pre_d        = '0;
      period_cnt_d = '0;
      if (bus.enable_i) begin
        state_d  = ST_RUN;
        shadow_d = bus.pwm_value_i;
        start_d  = 1'b1;
      end
    end else if (!bus.enable_i) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      pre_d        = '0;
      period_cnt_d = '0;
    end else begin
      tick  = (pre_q >= bus.prescale_i);
      wrap  = tick && (cnt_q >= bus.period_i);
      pre_d = tick ? '0 : pre_q + PRESCALE_WIDTH'(1);
      if (wrap) begin
        cnt_d        = '0;
        shadow_d     = bus.pwm_value_i;
        period_cnt_d = period_cnt_q + PERIOD_WIDTH'(1);
        start_d      = 1'b1;
      end else if (tick) begin
        cnt_d = cnt_q + COUNTER_WIDTH'(1);
      end
    end
  end

  // The pin compare uses next-state values so pwm_o lines up with the
  // registered counter and duty outputs. Idle parks at the inactive level.
  always_comb begin
    if (state_d == ST_RUN) begin
      pwm_d = (cnt_d < shadow_d) ^ bus.polarity_i;
    end else begin
      pwm_d = bus.polarity_i;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pre_q        <= '0;
      period_cnt_q <= '0;
      shadow_q     <= '0;
      start_q      <= 1'b0;
      pwm_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pre_q        <= pre_d;
      period_cnt_q <= period_cnt_d;
      shadow_q     <= shadow_d;
      start_q      <= start_d;
      pwm_q        <= pwm_d;
    end
  end

  assign bus.start_o          = start_q;
  assign bus.global_counter_o = {period_cnt_q, cnt_q};
  assign bus.pwm_o            = pwm_q;
  assign bus.duty_o           = shadow_q;

endmodule

// File: tb/tb_pwm_timer.sv
// tb_pwm_timer: directed, self-checking bench for pwm_timer.
// Expected outputs are pushed onto a scoreboard queue as each cycle's
// stimulus is set up and popped/compared one clock later, sampled 1 time
// unit after the rising edge. Expected run-time values come from a
// closed-form description of the waveform (clock index -> tick index ->
// counter / period count / pulse / pin level).
module tb_pwm_timer;

  localparam int CW  = 10;
  localparam int GCW = 20;
  localparam int PW  = 8;

  typedef struct {
    logic           start;
    logic [GCW-1:0] gc;
    logic           pwm;
    logic [CW-1:0]  duty;
    string          tag;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  pwm_timer_if #(.COUNTER_WIDTH(CW), .GLOBAL_COUNTER_WIDTH(GCW), .PRESCALE_WIDTH(PW)) bus_if ();

  pwm_timer #(.COUNTER_WIDTH(CW), .GLOBAL_COUNTER_WIDTH(GCW), .PRESCALE_WIDTH(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expectation and compare every output against it.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      compared++;
      assert (bus_if.start_o === e.start) else begin
        mismatched++;
        $error("FAIL %s start_o: got %b expected %b", e.tag, bus_if.start_o, e.start);
      end
      compared++;
      assert (bus_if.global_counter_o === e.gc) else begin
        mismatched++;
        $error("FAIL %s global_counter_o: got %h expected %h", e.tag, bus_if.global_counter_o, e.gc);
      end
      compared++;
      assert (bus_if.pwm_o === e.pwm) else begin
        mismatched++;
        $error("FAIL %s pwm_o: got %b expected %b", e.tag, bus_if.pwm_o, e.pwm);
      end
      compared++;
      assert (bus_if.duty_o === e.duty) else begin
        mismatched++;
        $error("FAIL %s duty_o: got %h expected %h", e.tag, bus_if.duty_o, e.duty);
      end
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic pushExp(input logic start, input logic [GCW-1:0] gc, input logic pwm,
                         input logic [CW-1:0] duty, input string tag);
    exp_t e;
    e.start = start;
    e.gc    = gc;
    e.pwm   = pwm;
    e.duty  = duty;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic resetCycle();
    pushExp(1'b0, '0, 1'b0, '0, "reset");
    stepCycle();
  endtask

  task automatic idleCycle(input logic pol, input int duty);
    pushExp(1'b0, '0, pol, duty[CW-1:0], "idle");
    stepCycle();
  endtask

  // Clock k after a period start (k=0 is the start_o cycle): the tick index
  // is k/(pre+1), the in-period count is tick%(per+1) and a new period
  // begins every (pre+1)*(per+1) clocks.
  task automatic applyStimulus(input int kStart, input int kEnd, input int per, input int pre,
                               input int duty, input logic pol, input int pbase, input string tag);
    for (int k = kStart; k < kEnd; k++) begin
      int t;
      int c;
      int pc;
      logic [GCW-1:0] gc;
      t  = k / (pre + 1);
      c  = t % (per + 1);
      pc = (pbase + t / (per + 1)) % 1024;
      gc = {pc[CW-1:0], c[CW-1:0]};
      pushExp((k % ((pre + 1) * (per + 1))) == 0, gc, (c < duty) ^ pol, duty[CW-1:0], tag);
      stepCycle();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n              = 1'b0;
    bus_if.enable_i    = 1'b0;
    bus_if.period_i    = 10'd9;
    bus_if.prescale_i  = 8'd0;
    bus_if.polarity_i  = 1'b0;
    bus_if.pwm_value_i = 10'd3;
    $display("[TB] reset");
    resetCycle();
    resetCycle();
    rst_n = 1'b1;
    idleCycle(1'b0, 0);

    $display("[TB] basic period and shadow timing");
    bus_if.enable_i = 1'b1;
    applyStimulus(0, 26, 9, 0, 3, 1'b0, 0, "basic");
    bus_if.pwm_value_i = 10'd7;
    applyStimulus(26, 30, 9, 0, 3, 1'b0, 0, "shadow_hold");
    applyStimulus(30, 45, 9, 0, 7, 1'b0, 0, "shadow_new");

    $display("[TB] disable / re-enable");
    bus_if.enable_i = 1'b0;
    idleCycle(1'b0, 7);
    idleCycle(1'b0, 7);
    bus_if.enable_i = 1'b1;
    applyStimulus(0, 12, 9, 0, 7, 1'b0, 0, "reenable");

    $display("[TB] prescale");
    bus_if.enable_i    = 1'b0;
    bus_if.prescale_i  = 8'd2;
    bus_if.period_i    = 10'd3;
    bus_if.pwm_value_i = 10'd2;
    idleCycle(1'b0, 7);
    bus_if.enable_i = 1'b1;
    applyStimulus(0, 36, 3, 2, 2, 1'b0, 0, "prescale");

    $display("[TB] extremes");
    bus_if.enable_i    = 1'b0;
    bus_if.prescale_i  = 8'd0;
    bus_if.period_i    = 10'd9;
    bus_if.pwm_value_i = 10'd0;
    idleCycle(1'b0, 2);
    bus_if.enable_i = 1'b1;
    applyStimulus(0, 20, 9, 0, 0, 1'b0, 0, "duty0");
    bus_if.enable_i    = 1'b0;
    bus_if.pwm_value_i = 10'd15;
    idleCycle(1'b0, 0);
    bus_if.enable_i = 1'b1;
    applyStimulus(0, 20, 9, 0, 15, 1'b0, 0, "duty_full");
    bus_if.enable_i   = 1'b0;
    bus_if.polarity_i = 1'b1;
    idleCycle(1'b1, 15);
    bus_if.enable_i = 1'b1;
    applyStimulus(0, 20, 9, 0, 15, 1'b1, 0, "duty_full_inv");
    bus_if.enable_i    = 1'b0;
    bus_if.pwm_value_i = 10'd0;
    idleCycle(1'b1, 15);
    bus_if.enable_i = 1'b1;
    applyStimulus(0, 20, 9, 0, 0, 1'b1, 0, "duty0_inv");

    $display("[TB] polarity change and period reduction mid-period");
    bus_if.enable_i    = 1'b0;
    bus_if.polarity_i  = 1'b0;
    bus_if.pwm_value_i = 10'd3;
    idleCycle(1'b0, 0);
    bus_if.enable_i = 1'b1;
    applyStimulus(0, 5, 9, 0, 3, 1'b0, 0, "pol_before");
    bus_if.polarity_i = 1'b1;
    applyStimulus(5, 17, 9, 0, 3, 1'b1, 0, "pol_after");
    bus_if.period_i    = 10'd3;
    bus_if.pwm_value_i = 10'd5;
    applyStimulus(0, 10, 3, 0, 5, 1'b1, 2, "period_shrink");

    $display("[TB] period 0 and period count wrap-around");
    bus_if.enable_i    = 1'b0;
    bus_if.polarity_i  = 1'b0;
    bus_if.period_i    = 10'd0;
    bus_if.pwm_value_i = 10'd1;
    idleCycle(1'b0, 5);
    bus_if.enable_i = 1'b1;
    applyStimulus(0, 1030, 0, 0, 1, 1'b0, 0, "period0");

    $display("[TB] reset mid-period");
    bus_if.enable_i    = 1'b0;
    bus_if.period_i    = 10'd9;
    bus_if.pwm_value_i = 10'd4;
    bus_if.polarity_i  = 1'b1;
    idleCycle(1'b1, 1);
    bus_if.enable_i = 1'b1;
    applyStimulus(0, 6, 9, 0, 4, 1'b1, 0, "pre_reset");
    rst_n = 1'b0;
    resetCycle();
    resetCycle();
    rst_n = 1'b1;
    applyStimulus(0, 12, 9, 0, 4, 1'b1, 0, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
